// File: rtl/ifu_pipe.sv
// In-order instruction fetch unit: issues sequential fetch requests, buffers
// responses in a small queue and hands instructions to decode in program order.
module ifu_pipe #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [31:0]     imem_rsp_data_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] inst_pc_o
);

   localparam int unsigned CW = $clog2(DEPTH);
   // Extra headroom: back-to-back redirects can stack more in-flight drops than DEPTH.
   localparam int unsigned DW = CW + 3;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   head_q, head_d;
   logic [CW:0]     cnt_q, cnt_d;
   logic [CW:0]     unf_q, unf_d;
   logic [DW-1:0]   drop_q, drop_d;
   logic [XLEN-1:0] epc_q   [DEPTH];
   logic [XLEN-1:0] epc_d   [DEPTH];
   logic [31:0]     einst_q [DEPTH];
   logic [31:0]     einst_d [DEPTH];

   logic            req_valid_s;
   logic            inst_valid_s;
   logic            acc_s;
   logic            pop_s;
   logic            rsp_drop_s;
   logic            rsp_fill_s;
   logic [CW:0]     filled_cnt_s;
   logic [CW-1:0]   tail_idx_s;
   logic [CW-1:0]   fill_idx_s;

   // Handshake qualifiers and queue slot selection; filled entries are always
   // the contiguous run starting at head because responses return in order.
   always_comb begin
      req_valid_s  = rst_ni & (cnt_q < DEPTH_C) & ~redirect_i;
      inst_valid_s = (cnt_q > unf_q) & ~redirect_i;
      acc_s        = req_valid_s & imem_req_ready_i;
      pop_s        = inst_valid_s & inst_ready_i;
      rsp_drop_s   = imem_rsp_valid_i & (drop_q != DW'(0));
      rsp_fill_s   = imem_rsp_valid_i & (drop_q == DW'(0)) & (unf_q != (CW+1)'(0));
      filled_cnt_s = cnt_q - unf_q;
      tail_idx_s   = head_q + cnt_q[CW-1:0];
      fill_idx_s   = head_q + filled_cnt_s[CW-1:0];
   end

   // Next-state: redirect flushes the queue and converts unfilled entries into drops.
   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      cnt_d   = cnt_q;
      unf_d   = unf_q;
      drop_d  = drop_q;
      epc_d   = epc_q;
      einst_d = einst_q;
      if (redirect_i) begin
         pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
         cnt_d  = (CW+1)'(0);
         unf_d  = (CW+1)'(0);
         drop_d = drop_q + DW'(unf_q) - DW'(rsp_drop_s | rsp_fill_s);
      end else begin
         if (acc_s) begin
            epc_d[tail_idx_s] = pc_q;
            pc_d              = pc_q + XLEN'(4);
         end else begin
            pc_d = pc_q;
         end
         if (rsp_drop_s) begin
            drop_d = drop_q - DW'(1);
         end else begin
            drop_d = drop_q;
         end
         if (rsp_fill_s) begin
            einst_d[fill_idx_s] = imem_rsp_data_i;
         end else begin
            einst_d = einst_q;
         end
         if (pop_s) begin
            head_d = head_q + CW'(1);
         end else begin
            head_d = head_q;
         end
         cnt_d = cnt_q + (CW+1)'(acc_s) - (CW+1)'(pop_s);
         unf_d = unf_q + (CW+1)'(acc_s) - (CW+1)'(rsp_fill_s);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q   <= RESET_PC;
         head_q <= '0;
         cnt_q  <= '0;
         unf_q  <= '0;
         drop_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            epc_q[i]   <= '0;
            einst_q[i] <= '0;
         end
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         cnt_q   <= cnt_d;
         unf_q   <= unf_d;
         drop_q  <= drop_d;
         epc_q   <= epc_d;
         einst_q <= einst_d;
      end
   end

   assign imem_req_valid_o = req_valid_s;
   assign imem_req_addr_o  = pc_q;
   assign inst_valid_o     = inst_valid_s;
   assign inst_o           = einst_q[head_q];
   assign inst_pc_o        = epc_q[head_q];

endmodule

// File: tb/tb_ifu_pipe.sv
// Randomized bench for ifu_pipe: an in-order memory model feeds the DUT and a
// queue-based reference model predicts every output each cycle.
module tb_ifu_pipe;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_ready, rsp_valid, redirect, inst_ready;
   logic [31:0] rsp_data, redirect_pc;
   logic        req_valid, inst_valid;
   logic [31:0] req_addr, inst, inst_pc;
   logic        w_req_valid, w_inst_valid;
   logic [31:0] w_req_addr, w_inst, w_inst_pc;

   always #5 clk = ~clk;

   ifu_pipe #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(req_addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_o(inst), .inst_pc_o(inst_pc)
   );

   ifu_pipe #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
      .clk_i(clk), .rst_ni(rst_n),
      .imem_req_valid_o(w_req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(w_req_addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .inst_valid_o(w_inst_valid), .inst_ready_i(inst_ready), .inst_o(w_inst), .inst_pc_o(w_inst_pc)
   );

   typedef struct {logic [31:0] pc; logic [31:0] inst; bit filled;} ent_t;
   typedef struct {logic [31:0] addr; int due;} mreq_t;

   ent_t        mq[$];
   mreq_t       mem[$];
   logic [31:0] mpc;
   int          mdrop;
   int          cyc;
   int          lat;
   int          dut_acc;
   int          total = 0;
   int          bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // One cycle: drive inputs at negedge, compare outputs, advance the reference model.
   task automatic step(input bit rdr, input logic [31:0] rpc, input bit rdy, input bit irdy);
      bit          rv;
      bit          exp_req, exp_iv;
      logic [31:0] rd;
      int          unf;
      int          fidx;
      @(negedge clk);
      rv = 1'b0;
      rd = 32'h0;
      if (mem.size() > 0 && mem[0].due <= cyc) begin
         rv = 1'b1;
         rd = mdata(mem[0].addr);
         mem.delete(0);
      end
      redirect = rdr; redirect_pc = rpc; req_ready = rdy; inst_ready = irdy;
      rsp_valid = rv; rsp_data = rd;
      #1;
      exp_req = (mq.size() < DEPTH) && !rdr;
      exp_iv  = (mq.size() > 0) && mq[0].filled && !rdr;
      check("req_valid", req_valid, exp_req);
      if (exp_req) check("req_addr", req_addr, mpc);
      check("inst_valid", inst_valid, exp_iv);
      if (exp_iv) begin
         check("inst", inst, mq[0].inst);
         check("inst_pc", inst_pc, mq[0].pc);
      end
      if (req_valid && rdy) dut_acc++;
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      if (rdr) begin
         if (rv) begin
            if (mdrop > 0) mdrop--;
            else if (unf > 0) unf--;
         end
         mdrop += unf;
         mq.delete();
         mpc = {rpc[31:2], 2'b00};
      end else begin
         if (rv) begin
            if (mdrop > 0) mdrop--;
            else begin
               fidx = -1;
               foreach (mq[i]) if (!mq[i].filled && fidx < 0) fidx = i;
               if (fidx >= 0) begin
                  mq[fidx].inst   = rd;
                  mq[fidx].filled = 1'b1;
               end
            end
         end
         if (exp_iv && irdy) mq.delete(0);
         if (exp_req && rdy) begin
            mq.push_back('{pc: mpc, inst: 32'h0, filled: 1'b0});
            mem.push_back('{addr: mpc, due: cyc + lat});
            mpc = mpc + 32'd4;
         end
      end
      cyc++;
   endtask

   // Asynchronous reset assertion away from any clock edge, with the memory reset too.
   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      redirect = 1'b0; rsp_valid = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
      #1;
      check("rst_req_valid", req_valid, 1'b0);
      check("rst_inst_valid", inst_valid, 1'b0);
      check("rst_w_req_valid", w_req_valid, 1'b0);
      mq.delete();
      mem.delete();
      mdrop = 0;
      mpc = RST_PC;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_req_valid", req_valid, 1'b0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit got;
      req_ready = 1'b0; rsp_valid = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
      rsp_data = 32'h0; redirect_pc = 32'h0;
      cyc = 0; lat = 1; dut_acc = 0; mdrop = 0; mpc = RST_PC;

      // Streaming with a 1-cycle memory, plus PC wrap in the second instance.
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b1);
         if (i == 0) begin
            check("wrap_valid", w_req_valid, 1'b1);
            check("wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
         end
         if (i == 1) check("wrap_addr1", w_req_addr, 32'h0000_0000);
      end

      // Decode stalled: queue fills to DEPTH and requests stop.
      apply_reset();
      dut_acc = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
      check("full_accepts", dut_acc, DEPTH);
      check("full_req_valid", req_valid, 1'b0);

      // Reset with a full queue, then a 3-cycle memory and a redirect.
      apply_reset();
      lat = 3;
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b1, 32'h8000_0103, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1);
      check("redirect_addr", req_addr, 32'h8000_0100);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         step(1'b0, 32'h0, 1'b1, 1'b1);
         if (inst_valid) begin
            got = 1'b1;
            check("redirect_first_pc", inst_pc, 32'h8000_0100);
         end
      end
      check("redirect_deliver_timeout", got, 1'b1);

      // Random traffic: redirects, stalls, varying latency.
      for (int n = 0; n < 4000; n++) begin
         if (n % 250 == 0) lat = $urandom_range(1, 3);
         step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
